half_mul_seq: RTL
=================

# half_mul_seq

Sequential half-precision magnitude multiplier, the inverse-direction companion to the half-precision divider in the FP unit. It consumes the same unpacked operand form the divider consumes (sign, biased exponent, 11-bit mantissa with explicit hidden bit) and returns a packed binary16 result plus the shared 5-bit flag vector. A shift-add datapath handles one multiplier bit per cycle behind a valid/ready handshake, followed by normalize, round-to-nearest-even and pack.

## Interface
Parameters:
- BIAS, 15, exponent bias.
- MB, 11, mantissa width including the hidden bit.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  operand offered.
- IN_READY  out  1  block can accept operands; high only in IDLE.
- SIGN_A, SIGN_B  in  1 each  operand signs.
- IN_EXP_A_HALF, IN_EXP_B_HALF  in  5 each  biased exponents.
- IN_MANT_A_HALF, IN_MANT_B_HALF  in  11 each  mantissas with hidden bit.
- OUT_VALID  out  1  Q/FLAGS valid.
- OUT_READY  in  1  consumer takes result.
- Q  out  16  packed binary16 result.
- FLAGS  out  5  [4]=INVALID, [3]=DIVZERO (always 0 here), [2]=UF, [1]=OF, [0]=INEXACT.

## Operation
- States: IDLE -> MUL -> RND -> DONE -> IDLE.
- IDLE: IN_READY=1; on IN_VALID&IN_READY, register operands, sign=SIGN_A^SIGN_B, exp sum = EA+EB-BIAS in 7-bit signed, clear 22-bit accumulator, bit counter=0; go MUL.
- Exponent 0 operands are subnormal: effective exponent 1, mantissa used as given.
- MUL: each cycle, if multiplier bit[counter] set, add multiplicand<<counter to accumulator; counter++; after bit 10 go RND.
- RND: if P[21], shift right 1 and exp+1; mantissa = top 11 bits, guard = next bit, sticky = OR of the rest; RNE; a rounding carry renormalizes (exp+1).
- Overflow (exp >= 31): Q = {sign,5'h1F,10'h0}, OF=1, INEXACT=1.
- Underflow (exp <= 0, product nonzero): flush to signed zero, UF=1, INEXACT=1.
- Otherwise INEXACT = guard|sticky.
- Zero product: signed zero, flags 0.
- DONE: OUT_VALID=1; Q/FLAGS stable until OUT_VALID&OUT_READY, then IDLE.

## Timing
- Reset values: IN_READY=0 while RST_N low, 1 on the first cycle after deassertion; OUT_VALID=0; Q=16'h0000; FLAGS=5'h00; state IDLE.
- Normal latency: OUT_VALID rises 13 cycles after the accepting edge (11 MUL, 1 RND, then DONE).
- No pipelining: one operation in flight. IN_VALID is ignored outside IDLE.
- If OUT_READY is already high when OUT_VALID rises, the result is taken that cycle and IN_READY is high the next cycle.
- Reset asserted mid-operation aborts immediately to IDLE; the partial result is discarded and OUT_VALID stays 0.

## Configuration
- HALF_MUL_SPECIAL_EN defined: in IDLE, operands with exponent 31 or a zero mantissa are short-circuited to DONE, with OUT_VALID on the cycle after acceptance:
  - NaN in, or Inf*0: Q=16'h7E00, INVALID=1.
  - Inf*finite nonzero: signed Inf, flags 0.
  - Zero*finite: signed zero, flags 0.
- HALF_MUL_SPECIAL_EN undefined: all operands take the full datapath and exponent 31 is treated as an ordinary value. INVALID is never set.

## Structure
- Shared package half_fp_pkg holds:
  - BIAS, EXP_MAX=31, QNAN=16'h7E00.
  - Flag bit index constants.
  - The state enum.
- The divider reuses these constants.
- Sub-module half_round_pack, combinational: takes the 22-bit product, signed exponent and sign; returns Q and FLAGS. It is shared with the divider's rounding stage.

## Test plan
- 1.5*2.0: exp 15, mant 0x600 times exp 16, mant 0x400 -> Q=0x4200, FLAGS=0, OUT_VALID 13 cycles after accept. With SIGN_A=1 -> Q=0xC200.
- Rounding: exp 15, mant 0x401 squared -> Q=0x3C02, FLAGS=5'b00001.
- Overflow: exp 30, mant 0x7FF times exp 16, mant 0x400 -> Q=0x7C00, FLAGS=5'b00011.
- Underflow: exp 1, mant 0x400 squared -> Q=0x0000, FLAGS=5'b00101.
- With HALF_MUL_SPECIAL_EN, Inf (exp 31, mant 0x400) * zero (exp 0, mant 0) -> Q=0x7E00, FLAGS=5'b10000, OUT_VALID 1 cycle after accept.
- Handshake and reset:
  - Hold OUT_READY=0 for 5 cycles: Q stable, IN_READY=0, and a new IN_VALID is ignored.
  - Assert RST_N=0 at MUL cycle 6: next state IDLE, OUT_VALID=0, Q=0.

Source files
------------

// File: rtl/half_fp_pkg.sv
// Constants, flag positions and FSM encoding shared by the half-precision multiplier and divider.
package half_fp_pkg;

    localparam int          BIAS    = 15;
    localparam int          EXP_MAX = 31;
    localparam logic [15:0] QNAN    = 16'h7E00;

    localparam int FLG_INVALID = 4;
    localparam int FLG_DIVZERO = 3;
    localparam int FLG_UF      = 2;
    localparam int FLG_OF      = 1;
    localparam int FLG_INEXACT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RND  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/half_mul_seq_if.sv
// Operand/result handshake bundle for half_mul_seq; master drives operands and takes results.
interface half_mul_seq_if #(
    parameter int MB = 11
);
    logic          IN_VALID;
    logic          IN_READY;
    logic          SIGN_A;
    logic          SIGN_B;
    logic [4:0]    IN_EXP_A_HALF;
    logic [4:0]    IN_EXP_B_HALF;
    logic [MB-1:0] IN_MANT_A_HALF;
    logic [MB-1:0] IN_MANT_B_HALF;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [15:0]   Q;
    logic [4:0]    FLAGS;

    modport master (
        output IN_VALID, SIGN_A, SIGN_B, IN_EXP_A_HALF, IN_EXP_B_HALF,
               IN_MANT_A_HALF, IN_MANT_B_HALF, OUT_READY,
        input  IN_READY, OUT_VALID, Q, FLAGS
    );

    modport slave (
        input  IN_VALID, SIGN_A, SIGN_B, IN_EXP_A_HALF, IN_EXP_B_HALF,
               IN_MANT_A_HALF, IN_MANT_B_HALF, OUT_READY,
        output IN_READY, OUT_VALID, Q, FLAGS
    );
endinterface

// File: rtl/half_round_pack.sv
// Combinational normalize, round-to-nearest-even and binary16 pack of a 2*MB-bit product.
// Zero latency; no handshake.
module half_round_pack
    import half_fp_pkg::*;
#(
    parameter int MB = 11
) (
    input  logic [2*MB-1:0]  prod,
    input  logic signed [6:0] exp_in,
    input  logic             sign,
    output logic [15:0]      q,
    output logic [4:0]       flags
);
    localparam int PW = 2 * MB;

    logic              norm;
    logic [PW-2:0]     shifted;
    logic [MB-1:0]     mant;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [MB:0]       mant_r;
    logic [MB-2:0]     frac;
    logic signed [7:0] exp_n;
    logic signed [7:0] exp_f;

    always_comb begin
        norm     = prod[PW-1];
        shifted  = norm ? prod[PW-1:1] : prod[PW-2:0];
        mant     = shifted[PW-2:MB-1];
        guard    = shifted[MB-2];
        // the bit dropped by the normalizing shift still counts toward sticky
        sticky   = (|shifted[MB-3:0]) | (norm & prod[0]);
        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + {{MB{1'b0}}, round_up};
        frac     = mant_r[MB] ? mant_r[MB-1:1] : mant_r[MB-2:0];
        exp_n    = {exp_in[6], exp_in} + {7'd0, norm};
        exp_f    = exp_n + {7'd0, mant_r[MB]};

        q     = 16'h0000;
        flags = 5'h00;
        if (prod == '0) begin
            q = {sign, 15'h0000};
        end else if (exp_f >= $signed(8'(EXP_MAX))) begin
            q                  = {sign, 5'h1F, 10'h000};
            flags[FLG_OF]      = 1'b1;
            flags[FLG_INEXACT] = 1'b1;
        end else if (exp_f <= 8'sd0) begin
            q                  = {sign, 15'h0000};
            flags[FLG_UF]      = 1'b1;
            flags[FLG_INEXACT] = 1'b1;
        end else begin
            q                  = {sign, exp_f[4:0], frac};
            flags[FLG_INEXACT] = guard | sticky;
        end
    end

endmodule

// File: rtl/half_mul_seq.sv
// Sequential binary16 multiplier, one multiplier bit per cycle; HALF_MUL_SPECIAL_EN short-circuits Inf/NaN/zero.
// Latency: result valid in the 13th cycle after accept (11 MUL + 1 RND), or the 1st cycle on the special path.
// Backpressure: single operation in flight; IN_READY only in IDLE, result held until OUT_READY.
module half_mul_seq #(
    parameter int BIAS = half_fp_pkg::BIAS,
    parameter int MB   = 11
) (
    input logic           CLK,
    input logic           RST_N,
    half_mul_seq_if.slave bus
);
    import half_fp_pkg::*;

    state_t            state;
    logic              sign_q;
    logic signed [6:0] exp_q;
    logic [MB-1:0]     mcand;
    logic [MB-1:0]     mplier;
    logic [2*MB-1:0]   acc;
    logic [3:0]        cnt;
    logic [15:0]       q_q;
    logic [4:0]        flags_q;

    logic [15:0]       rp_q;
    logic [4:0]        rp_flags;
    logic [4:0]        ea_eff;
    logic [4:0]        eb_eff;
    logic signed [6:0] exp_sum;
    logic              accept;

    // subnormal operands sit at effective exponent 1
    assign ea_eff  = (bus.IN_EXP_A_HALF == 5'd0) ? 5'd1 : bus.IN_EXP_A_HALF;
    assign eb_eff  = (bus.IN_EXP_B_HALF == 5'd0) ? 5'd1 : bus.IN_EXP_B_HALF;
    assign exp_sum = {2'b00, ea_eff} + {2'b00, eb_eff} - 7'(BIAS);

    assign bus.IN_READY  = RST_N && (state == ST_IDLE);
    assign bus.OUT_VALID = (state == ST_DONE);
    assign bus.Q         = q_q;
    assign bus.FLAGS     = flags_q;
    assign accept        = bus.IN_VALID && bus.IN_READY;

`ifdef HALF_MUL_SPECIAL_EN
    logic        a_e31, b_e31, a_nan, b_nan, a_zero, b_zero;
    logic        special;
    logic [15:0] spec_q;
    logic [4:0]  spec_flags;

    always_comb begin
        a_e31   = (bus.IN_EXP_A_HALF == 5'h1F);
        b_e31   = (bus.IN_EXP_B_HALF == 5'h1F);
        a_nan   = a_e31 && (bus.IN_MANT_A_HALF[MB-2:0] != '0);
        b_nan   = b_e31 && (bus.IN_MANT_B_HALF[MB-2:0] != '0);
        a_zero  = !a_e31 && (bus.IN_MANT_A_HALF == '0);
        b_zero  = !b_e31 && (bus.IN_MANT_B_HALF == '0);
        special = a_e31 || b_e31 || a_zero || b_zero;

        spec_q     = 16'h0000;
        spec_flags = 5'h00;
        if (a_nan || b_nan || (a_e31 && b_zero) || (b_e31 && a_zero)) begin
            spec_q                  = QNAN;
            spec_flags[FLG_INVALID] = 1'b1;
        end else if (a_e31 || b_e31) begin
            spec_q = {bus.SIGN_A ^ bus.SIGN_B, 5'h1F, 10'h000};
        end else begin
            spec_q = {bus.SIGN_A ^ bus.SIGN_B, 15'h0000};
        end
    end
`endif

    half_round_pack #(.MB(MB)) u_round_pack (
        .prod   (acc),
        .exp_in (exp_q),
        .sign   (sign_q),
        .q      (rp_q),
        .flags  (rp_flags)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            q_q     <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sign_q <= bus.SIGN_A ^ bus.SIGN_B;
                        exp_q  <= exp_sum;
                        mcand  <= bus.IN_MANT_A_HALF;
                        mplier <= bus.IN_MANT_B_HALF;
                        acc    <= '0;
                        cnt    <= '0;
`ifdef HALF_MUL_SPECIAL_EN
                        if (special) begin
                            q_q     <= spec_q;
                            flags_q <= spec_flags;
                            state   <= ST_DONE;
                        end else begin
                            state   <= ST_MUL;
                        end
`else
                        state  <= ST_MUL;
`endif
                    end
                end
                ST_MUL: begin
                    if (mplier[cnt]) begin
                        acc <= acc + ({{MB{1'b0}}, mcand} << cnt);
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(MB - 1)) begin
                        state <= ST_RND;
                    end
                end
                ST_RND: begin
                    q_q     <= rp_q;
                    flags_q <= rp_flags;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.OUT_READY) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
